// File: rtl/prl_rx_pkg.sv
// Shared codes, state encoding and length helpers for the PRL RX parser.
package prl_rx_pkg;

    // Message-type codes reported to the message interface
    localparam logic [1:0] MT_CONTROL  = 2'b00;
    localparam logic [1:0] MT_DATA     = 2'b01;
    localparam logic [1:0] MT_EXTENDED = 2'b10;

    // Header-type codes that carry a decoded first data object
    localparam logic [4:0] HT_REQUEST = 5'b00010;
    localparam logic [4:0] HT_BIST    = 5'b00011;

    // BIST data-object mode selecting test data
    localparam logic [3:0] BIST_TEST_DATA = 4'b1000;

    // Largest legal byte count (2 header bytes + 7 data objects); counter stops one above
    localparam logic [4:0] MAX_BYTES = 5'd30;
    localparam logic [4:0] CNT_SAT   = MAX_BYTES + 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DO   = 2'd2,
        ST_SKIP = 2'd3
    } state_t;

    // Expected byte count for a non-extended message with num_do data objects
    function automatic logic [4:0] exp_len(input logic [2:0] num_do);
        return 5'd2 + {num_do, 2'b00};
    endfunction

    function automatic logic [1:0] msg_type(input logic ext, input logic [2:0] num_do);
        if (ext)
            return MT_EXTENDED;
        else if (num_do != 3'd0)
            return MT_DATA;
        else
            return MT_CONTROL;
    endfunction

endpackage

// File: rtl/prl_rx_parser_if.sv
// PHY-to-PRL receive byte stream: SOP/EOP framing, byte strobe and CRC verdict.
interface prl_rx_parser_if;
    logic       phy2prl_rx_sop_det;
    logic [2:0] phy2prl_rx_sop_type;
    logic       phy2prl_rx_data_vld;
    logic [7:0] phy2prl_rx_data;
    logic       phy2prl_rx_eop;
    logic       phy2prl_rx_crc_ok;

    modport master (
        output phy2prl_rx_sop_det, phy2prl_rx_sop_type, phy2prl_rx_data_vld,
               phy2prl_rx_data, phy2prl_rx_eop, phy2prl_rx_crc_ok
    );

    modport slave (
        input  phy2prl_rx_sop_det, phy2prl_rx_sop_type, phy2prl_rx_data_vld,
               phy2prl_rx_data, phy2prl_rx_eop, phy2prl_rx_crc_ok
    );
endinterface

// File: rtl/prl_rx_do_asm.sv
// Byte counter plus little-endian assembly of the first data object (bytes 2..5).
// The *_nxt outputs already include the byte of the current cycle, so a byte that
// arrives together with eop is accounted for before the eop verdict.
module prl_rx_do_asm
    import prl_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    input  logic        chk_en,
    input  logic [4:0]  limit,
    output logic [4:0]  cnt,
    output logic [4:0]  cnt_nxt,
    output logic        ovf_nxt,
    output logic [31:0] word_nxt
);

    logic        ovf;
    logic [31:0] word;

    // Post-byte view of counter, overflow flag and assembled word
    always_comb begin
        cnt_nxt  = cnt;
        ovf_nxt  = ovf;
        word_nxt = word;
        if (byte_vld) begin
            if (cnt != CNT_SAT)
                cnt_nxt = cnt + 5'd1;
            // new count (cnt+1) exceeds the limit exactly when cnt >= limit
            if (chk_en && (cnt >= limit))
                ovf_nxt = 1'b1;
            case (cnt)
                5'd2:    word_nxt[7:0]   = byte_data;
                5'd3:    word_nxt[15:8]  = byte_data;
                5'd4:    word_nxt[23:16] = byte_data;
                5'd5:    word_nxt[31:24] = byte_data;
                default: ;
            endcase
        end
    end

    // Working registers; a new SOP restarts counting from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            ovf  <= 1'b0;
            word <= '0;
        end else if (clr) begin
            cnt  <= '0;
            ovf  <= 1'b0;
            word <= '0;
        end else begin
            cnt  <= cnt_nxt;
            ovf  <= ovf_nxt;
            word <= word_nxt;
        end
    end

endmodule

// File: rtl/prl_rx_parser.sv
// USB-PD RX message parser: framing FSM, header capture, end-of-packet verdict
// and decode of the first data object into held output fields.
module prl_rx_parser
    import prl_rx_pkg::*;
#(
    parameter logic [2:0] APDO_POS = 3'd5
) (
    input  logic                clk,
    input  logic                rst_n,
    prl_rx_parser_if.slave      phy,
    output logic                prl_rx_parser_done,
    output logic                prl_rx_parser_err,
    output logic [1:0]          prl_rx_parser_message_type,
    output logic [2:0]          prl_rx_parser_sop_type,
    output logic [4:0]          prl_rx_parser_header_type,
    output logic [2:0]          prl_rx_parser_message_id,
    output logic [2:0]          prl_rx_parser_num_do,
    output logic                prl_rx_parser_data_bist_mode,
    output logic                prl_rx_parser_data_request_pdo_type,
    output logic [10:0]         prl_rx_parser_data_request_op_cur,
    output logic [9:0]          prl_rx_parser_data_request_max_op_cur,
    output logic                prl_rx_parser_data_request_mismatch_flag
);

    state_t      state, state_nxt;
    logic [2:0]  sop_w;
    logic [15:0] hdr, hdr_nxt;
    logic [4:0]  cnt, cnt_nxt, limit;
    logic        ovf_nxt, chk_en, active;
    logic [31:0] word_nxt;
    logic        ext, data_msg, pps, eop_ok, done_nxt, err_nxt;
    logic [2:0]  num_do;
    logic        unused_bits;

    assign unused_bits = ^{hdr_nxt[8:5], word_nxt[27], word_nxt[25:20]};

    // Length check runs once the header is complete (HDR with num_do==0) or while in DO
    assign chk_en = ((state == ST_HDR) && (cnt >= 5'd2)) || (state == ST_DO);
    assign limit  = exp_len(hdr[14:12]);

    prl_rx_do_asm u_do_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (phy.phy2prl_rx_sop_det),
        .byte_vld  (phy.phy2prl_rx_data_vld),
        .byte_data (phy.phy2prl_rx_data),
        .chk_en    (chk_en),
        .limit     (limit),
        .cnt       (cnt),
        .cnt_nxt   (cnt_nxt),
        .ovf_nxt   (ovf_nxt),
        .word_nxt  (word_nxt)
    );

    // Header capture, eop verdict and next-state selection
    always_comb begin
        active  = (state != ST_IDLE);
        hdr_nxt = hdr;
        if ((state == ST_HDR) && phy.phy2prl_rx_data_vld) begin
            if (cnt == 5'd0)
                hdr_nxt[7:0] = phy.phy2prl_rx_data;
            else if (cnt == 5'd1)
                hdr_nxt[15:8] = phy.phy2prl_rx_data;
        end

        ext      = hdr_nxt[15];
        num_do   = hdr_nxt[14:12];
        data_msg = !ext && (num_do != 3'd0);
        pps      = (word_nxt[30:28] >= APDO_POS);

        eop_ok = phy.phy2prl_rx_crc_ok && !ovf_nxt && (cnt_nxt >= 5'd2) &&
                 (ext || (cnt_nxt == exp_len(num_do)));
        done_nxt = active && phy.phy2prl_rx_eop && eop_ok;
        // eop decides the old message; a lone sop in mid-message is an abort
        err_nxt  = active && ((phy.phy2prl_rx_eop && !eop_ok) ||
                              (phy.phy2prl_rx_sop_det && !phy.phy2prl_rx_eop));

        state_nxt = state;
        if (phy.phy2prl_rx_sop_det)
            state_nxt = ST_HDR;
        else if (active && phy.phy2prl_rx_eop)
            state_nxt = ST_IDLE;
        else if ((state == ST_HDR) && phy.phy2prl_rx_data_vld && (cnt == 5'd1)) begin
            if (ext)
                state_nxt = ST_SKIP;
            else if (num_do != 3'd0)
                state_nxt = ST_DO;
        end
    end

    // FSM state, latched SOP type and working header
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sop_w <= '0;
            hdr   <= '0;
        end else begin
            state <= state_nxt;
            if (phy.phy2prl_rx_sop_det) begin
                sop_w <= phy.phy2prl_rx_sop_type;
                hdr   <= '0;
            end else begin
                hdr   <= hdr_nxt;
            end
        end
    end

    // Strobes one cycle after the verdict; fields load only on done and otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prl_rx_parser_done                       <= 1'b0;
            prl_rx_parser_err                        <= 1'b0;
            prl_rx_parser_message_type               <= '0;
            prl_rx_parser_sop_type                   <= '0;
            prl_rx_parser_header_type                <= '0;
            prl_rx_parser_message_id                 <= '0;
            prl_rx_parser_num_do                     <= '0;
            prl_rx_parser_data_bist_mode             <= 1'b0;
            prl_rx_parser_data_request_pdo_type      <= 1'b0;
            prl_rx_parser_data_request_op_cur        <= '0;
            prl_rx_parser_data_request_max_op_cur    <= '0;
            prl_rx_parser_data_request_mismatch_flag <= 1'b0;
        end else begin
            prl_rx_parser_done <= done_nxt;
            prl_rx_parser_err  <= err_nxt;
            if (done_nxt) begin
                prl_rx_parser_message_type <= msg_type(ext, num_do);
                prl_rx_parser_sop_type     <= sop_w;
                prl_rx_parser_header_type  <= hdr_nxt[4:0];
                prl_rx_parser_message_id   <= hdr_nxt[11:9];
                prl_rx_parser_num_do       <= num_do;
                if (data_msg && (hdr_nxt[4:0] == HT_REQUEST)) begin
                    prl_rx_parser_data_request_pdo_type      <= pps;
                    prl_rx_parser_data_request_op_cur        <= pps ? word_nxt[19:9]
                                                                    : {1'b0, word_nxt[19:10]};
                    prl_rx_parser_data_request_max_op_cur    <= pps ? {3'b000, word_nxt[6:0]}
                                                                    : word_nxt[9:0];
                    prl_rx_parser_data_request_mismatch_flag <= word_nxt[26];
                end
                if (data_msg && (hdr_nxt[4:0] == HT_BIST))
                    prl_rx_parser_data_bist_mode <= (word_nxt[31:28] == BIST_TEST_DATA);
            end
        end
    end

endmodule

// File: tb/tb_prl_rx_parser.sv
// Directed bench for prl_rx_parser: a table of whole messages with hand-computed
// outcomes, followed by hand-written abort / same-cycle / reset sequences.
module tb_prl_rx_parser;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prl_rx_parser_if sif ();

    logic        done, err, bist, pdo, mm;
    logic [1:0]  mt;
    logic [2:0]  st, id, nd;
    logic [4:0]  ht;
    logic [10:0] op;
    logic [9:0]  mx;

    prl_rx_parser #(.APDO_POS(3'd5)) dut (
        .clk                                      (clk),
        .rst_n                                    (rst_n),
        .phy                                      (sif),
        .prl_rx_parser_done                       (done),
        .prl_rx_parser_err                        (err),
        .prl_rx_parser_message_type               (mt),
        .prl_rx_parser_sop_type                   (st),
        .prl_rx_parser_header_type                (ht),
        .prl_rx_parser_message_id                 (id),
        .prl_rx_parser_num_do                     (nd),
        .prl_rx_parser_data_bist_mode             (bist),
        .prl_rx_parser_data_request_pdo_type      (pdo),
        .prl_rx_parser_data_request_op_cur        (op),
        .prl_rx_parser_data_request_max_op_cur    (mx),
        .prl_rx_parser_data_request_mismatch_flag (mm)
    );

    logic [39:0] dut_fields, dut_strb;
    assign dut_fields = {mt, st, ht, id, nd, bist, pdo, op, mx, mm};
    assign dut_strb   = {38'd0, done, err};

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  sop;
        int          n;
        logic [79:0] bytes;
        logic        crc;
        logic [1:0]  strobe;
        logic [39:0] fields;
    } vec_t;

    vec_t vecs [12];

    localparam logic [1:0] DONE = 2'b10;
    localparam logic [1:0] ERR  = 2'b01;
    localparam logic [1:0] NONE = 2'b00;

    function automatic logic [39:0] fld(input logic [1:0] f_mt, input logic [2:0] f_st,
                                        input logic [4:0] f_ht, input logic [2:0] f_id,
                                        input logic [2:0] f_nd, input logic f_bist,
                                        input logic f_pdo, input logic [10:0] f_op,
                                        input logic [9:0] f_mx, input logic f_mm);
        return {f_mt, f_st, f_ht, f_id, f_nd, f_bist, f_pdo, f_op, f_mx, f_mm};
    endfunction

    function automatic vec_t mk(input logic [2:0] s, input int n, input logic [79:0] b,
                                input logic c, input logic [1:0] sb, input logic [39:0] f);
        vec_t v;
        v.sop = s; v.n = n; v.bytes = b; v.crc = c; v.strobe = sb; v.fields = f;
        return v;
    endfunction

    function automatic logic [39:0] strb(input logic [1:0] s);
        return {38'd0, s};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sop(input logic [2:0] t);
        sif.phy2prl_rx_sop_det  = 1'b1;
        sif.phy2prl_rx_sop_type = t;
        tick();
        sif.phy2prl_rx_sop_det  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        sif.phy2prl_rx_data_vld = 1'b1;
        sif.phy2prl_rx_data     = b;
        tick();
        sif.phy2prl_rx_data_vld = 1'b0;
    endtask

    task automatic send_eop(input logic c);
        sif.phy2prl_rx_eop    = 1'b1;
        sif.phy2prl_rx_crc_ok = c;
        tick();
        sif.phy2prl_rx_eop    = 1'b0;
        sif.phy2prl_rx_crc_ok = 1'b0;
    endtask

    task automatic send_bytes(input int n, input logic [79:0] b);
        for (int j = 0; j < n; j++)
            send_byte(b[8*j +: 8]);
    endtask

    initial begin
        sif.phy2prl_rx_sop_det  = 1'b0;
        sif.phy2prl_rx_sop_type = 3'd0;
        sif.phy2prl_rx_data_vld = 1'b0;
        sif.phy2prl_rx_data     = 8'd0;
        sif.phy2prl_rx_eop      = 1'b0;
        sif.phy2prl_rx_crc_ok   = 1'b0;
        rst_n = 1'b0;

        //           sop   n  bytes (byte0 in LSBs)        crc  strobe  mt st  ht     id nd bist pdo op       mx       mm
        vecs[0]  = mk(3'd0, 2, 80'h0641,                  1, DONE, fld(0, 0, 5'h01, 3, 0, 0, 0, 11'h000, 10'h000, 0));
        vecs[1]  = mk(3'd1, 6, 80'h1404B12C_1402,         1, DONE, fld(1, 1, 5'h02, 2, 1, 0, 0, 11'h12C, 10'h12C, 1));
        vecs[2]  = mk(3'd2, 6, 80'h5190A03C_1602,         1, DONE, fld(1, 2, 5'h02, 3, 1, 0, 1, 11'h050, 10'h03C, 0));
        vecs[3]  = mk(3'd0, 6, 80'h80000000_1003,         1, DONE, fld(1, 0, 5'h03, 0, 1, 1, 1, 11'h050, 10'h03C, 0));
        vecs[4]  = mk(3'd0, 2, 80'h0841,                  1, DONE, fld(0, 0, 5'h01, 4, 0, 1, 1, 11'h050, 10'h03C, 0));
        vecs[5]  = mk(3'd3, 5, 80'h332211_1202,           1, ERR,  fld(0, 0, 5'h01, 4, 0, 1, 1, 11'h050, 10'h03C, 0));
        vecs[6]  = mk(3'd3, 7, 80'h5544332211_1202,       1, ERR,  fld(0, 0, 5'h01, 4, 0, 1, 1, 11'h050, 10'h03C, 0));
        vecs[7]  = mk(3'd1, 2, 80'h0641,                  0, ERR,  fld(0, 0, 5'h01, 4, 0, 1, 1, 11'h050, 10'h03C, 0));
        vecs[8]  = mk(3'd4, 7, 80'hEEDDCCBBAA_900F,       1, DONE, fld(2, 4, 5'h0F, 0, 1, 1, 1, 11'h050, 10'h03C, 0));
        vecs[9]  = mk(3'd5, 3, 80'h00_0641,               1, ERR,  fld(2, 4, 5'h0F, 0, 1, 1, 1, 11'h050, 10'h03C, 0));
        vecs[10] = mk(3'd5, 1, 80'h41,                    1, ERR,  fld(2, 4, 5'h0F, 0, 1, 1, 1, 11'h050, 10'h03C, 0));
        vecs[11] = mk(3'd6, 6, 80'h44332211_1201,         1, DONE, fld(1, 6, 5'h01, 1, 1, 1, 1, 11'h050, 10'h03C, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_fields", dut_fields, 40'd0);
        check("reset_strobe", dut_strb, strb(NONE));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            send_sop(vecs[i].sop);
            send_bytes(vecs[i].n, vecs[i].bytes);
            send_eop(vecs[i].crc);
            check($sformatf("vec%0d_strobe", i), dut_strb, strb(vecs[i].strobe));
            check($sformatf("vec%0d_fields", i), dut_fields, vecs[i].fields);
            tick();
            check($sformatf("vec%0d_pulse", i), dut_strb, strb(NONE));
        end

        // Abort after three bytes, then the new message completes with the new SOP type
        send_sop(3'd1);
        send_bytes(3, 80'h2C_1402);
        send_sop(3'd5);
        check("abort_strobe", dut_strb, strb(ERR));
        check("abort_fields", dut_fields, fld(1, 6, 5'h01, 1, 1, 1, 1, 11'h050, 10'h03C, 0));
        send_bytes(2, 80'h0A41);
        send_eop(1'b1);
        check("after_abort_strobe", dut_strb, strb(DONE));
        check("after_abort_fields", dut_fields, fld(0, 5, 5'h01, 5, 0, 1, 1, 11'h050, 10'h03C, 0));

        // Last byte in the same cycle as eop
        send_sop(3'd2);
        send_byte(8'h41);
        sif.phy2prl_rx_data_vld = 1'b1;
        sif.phy2prl_rx_data     = 8'h06;
        send_eop(1'b1);
        sif.phy2prl_rx_data_vld = 1'b0;
        check("byte_eop_strobe", dut_strb, strb(DONE));
        check("byte_eop_fields", dut_fields, fld(0, 2, 5'h01, 3, 0, 1, 1, 11'h050, 10'h03C, 0));

        // eop of the old message and sop of the next in the same cycle
        send_sop(3'd3);
        send_bytes(2, 80'h0241);
        sif.phy2prl_rx_sop_det  = 1'b1;
        sif.phy2prl_rx_sop_type = 3'd6;
        send_eop(1'b1);
        sif.phy2prl_rx_sop_det  = 1'b0;
        check("sop_eop_strobe", dut_strb, strb(DONE));
        check("sop_eop_fields", dut_fields, fld(0, 3, 5'h01, 1, 0, 1, 1, 11'h050, 10'h03C, 0));
        send_bytes(2, 80'h0C41);
        send_eop(1'b1);
        check("sop_eop_next_strobe", dut_strb, strb(DONE));
        check("sop_eop_next_fields", dut_fields, fld(0, 6, 5'h01, 6, 0, 1, 1, 11'h050, 10'h03C, 0));

        // Reset in mid-message clears everything and leaves the FSM idle
        send_sop(3'd1);
        send_byte(8'h02);
        rst_n = 1'b0;
        #1;
        check("midreset_fields", dut_fields, 40'd0);
        check("midreset_strobe", dut_strb, strb(NONE));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_eop(1'b1);
        check("idle_eop_ignored", dut_strb, strb(NONE));
        send_bytes(2, 80'h0641);
        send_eop(1'b1);
        check("idle_data_ignored", dut_strb, strb(NONE));
        send_sop(3'd0);
        send_bytes(2, 80'h0641);
        send_eop(1'b1);
        check("post_reset_strobe", dut_strb, strb(DONE));
        check("post_reset_fields", dut_fields, fld(0, 0, 5'h01, 3, 0, 0, 0, 11'h000, 10'h000, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
